// File: rtl/window_pos_ms.sv
// Multi-scale window position tracker: queues scale-tagged window positions
// and pairs them in order with classifier results to emit detection beats.
module window_pos_ms #(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int SCALE_NUM  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int W_CNT      = 16,
  parameter int REPORT_ALL = 0,
  localparam int W_X = $clog2(IMG_WIDTH),
  localparam int W_Y = $clog2(IMG_HEIGHT),
  localparam int W_S = (SCALE_NUM > 2) ? $clog2(SCALE_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             window_pos_valid,
  output logic             window_pos_ready,
  input  logic             window_pos_eot,
  input  logic [W_X-1:0]   window_pos_x,
  input  logic [W_Y-1:0]   window_pos_y,
  input  logic [W_S-1:0]   window_pos_scale,
  input  logic             result_valid,
  output logic             result_ready,
  input  logic             result,
  output logic             detect_pos_valid,
  input  logic             detect_pos_ready,
  output logic             detect_pos_eot,
  output logic             detect_pos_hit,
  output logic [W_X-1:0]   detect_pos_x,
  output logic [W_Y-1:0]   detect_pos_y,
  output logic [W_S-1:0]   detect_pos_scale,
  output logic [W_CNT-1:0] detect_count,
  output logic             scale_err
);

  localparam int W_E = 1 + W_S + W_Y + W_X;
  localparam int W_P = $clog2(FIFO_DEPTH);
  localparam int W_U = W_P + 1;
  localparam logic [W_U-1:0] DEPTH = W_U'(FIFO_DEPTH);
  localparam logic [W_S:0] S_LIM = (W_S + 1)'(SCALE_NUM);
  localparam logic RA = (REPORT_ALL != 0);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state;
  logic [W_E-1:0]     mem [FIFO_DEPTH];
  logic [W_P-1:0]     wr_ptr;
  logic [W_P-1:0]     rd_ptr;
  logic [W_U-1:0]     used;
  logic [W_CNT-1:0]   hit_cnt;
  logic [W_CNT-1:0]   cnt_next;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               out_free;
  logic               emit;
  logic               head_eot;
  logic [W_S-1:0]     head_scale;
  logic [W_Y-1:0]     head_y;
  logic [W_X-1:0]     head_x;

  assign full     = (used == DEPTH);
  assign empty    = (used == '0);
  assign out_free = !detect_pos_valid || detect_pos_ready;

  assign window_pos_ready = !full;
  assign result_ready     = (state == RUN) && !empty && out_free;

  assign push = window_pos_valid && !full;
  assign pop  = result_valid && result_ready;

  assign {head_eot, head_scale, head_y, head_x} = mem[rd_ptr];
  assign emit = result || head_eot || RA;

  // Saturating hit count including the result being accepted now
  always_comb begin
    cnt_next = hit_cnt;
    if (result && (hit_cnt != '1)) cnt_next = hit_cnt + W_CNT'(1);
  end

  // Pending-position storage, written on push
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {window_pos_eot, window_pos_scale,
                      window_pos_y, window_pos_x};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + W_P'(1);
      if (pop)  rd_ptr <= rd_ptr + W_P'(1);
      unique case ({push, pop})
        2'b10:   used <= used + W_U'(1);
        2'b01:   used <= used - W_U'(1);
        default: used <= used;
      endcase
    end
  end

  // Sticky flag for out-of-range scale tags
  always_ff @(posedge clk) begin
    if (rst)
      scale_err <= 1'b0;
    else if (push && ({1'b0, window_pos_scale} >= S_LIM))
      scale_err <= 1'b1;
  end

  // Frame FSM, hit counter and registered detection beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      hit_cnt          <= '0;
      detect_pos_valid <= 1'b0;
      detect_pos_eot   <= 1'b0;
      detect_pos_hit   <= 1'b0;
      detect_pos_x     <= '0;
      detect_pos_y     <= '0;
      detect_pos_scale <= '0;
      detect_count     <= '0;
    end else begin
      if (pop) hit_cnt <= head_eot ? '0 : cnt_next;

      if (pop && emit) begin
        detect_pos_valid <= 1'b1;
        detect_pos_hit   <= result;
        detect_pos_eot   <= head_eot;
        detect_pos_x     <= head_x;
        detect_pos_y     <= head_y;
        detect_pos_scale <= head_scale;
        detect_count     <= head_eot ? cnt_next : '0;
      end else if (detect_pos_ready) begin
        detect_pos_valid <= 1'b0;
        detect_count     <= '0;
      end

      unique case (state)
        RUN:
          if (pop && head_eot) state <= DRAIN;
        DRAIN:
          if (detect_pos_valid && detect_pos_ready && detect_pos_eot)
            state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_window_pos_ms.sv
// Bench for window_pos_ms: two instances (REPORT_ALL 0 and 1) behind a
// select mux, checked against a frame-level reference model.
module tb_window_pos_ms;

  localparam int W_X = 6;
  localparam int W_Y = 6;
  localparam int W_S = 2;
  localparam int W_C = 3;
  localparam int CMAX = 7;

  typedef struct {
    logic [W_X-1:0] x;
    logic [W_Y-1:0] y;
    logic [W_S-1:0] s;
    logic           e;
  } win_t;

  typedef struct {
    logic [W_X-1:0] x;
    logic [W_Y-1:0] y;
    logic [W_S-1:0] s;
    logic           hit;
    logic           eot;
    logic [W_C-1:0] cnt;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic pv = 1'b0, pe = 1'b0, rv = 1'b0, rb = 1'b0, dr = 1'b1;
  logic [W_X-1:0] px = '0;
  logic [W_Y-1:0] py = '0;
  logic [W_S-1:0] ps = '0;

  logic p_rdy, r_rdy, d_v, d_e, d_h, s_err;
  logic [W_X-1:0] d_x;
  logic [W_Y-1:0] d_y;
  logic [W_S-1:0] d_s;
  logic [W_C-1:0] d_c;

  logic a_prdy, a_rrdy, a_v, a_e, a_h, a_err;
  logic [W_X-1:0] a_x;
  logic [W_Y-1:0] a_y;
  logic [W_S-1:0] a_s;
  logic [W_C-1:0] a_c;
  logic b_prdy, b_rrdy, b_v, b_e, b_h, b_err;
  logic [W_X-1:0] b_x;
  logic [W_Y-1:0] b_y;
  logic [W_S-1:0] b_s;
  logic [W_C-1:0] b_c;

  win_t  wq[$];
  logic  rq[$];
  beat_t exp_q[$];
  int    wi, ri;
  int    checks = 0;
  int    passed = 0;

  always #5 clk = ~clk;

  window_pos_ms #(
    .IMG_WIDTH(45), .IMG_HEIGHT(45), .SCALE_NUM(3),
    .FIFO_DEPTH(8), .W_CNT(W_C), .REPORT_ALL(0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .window_pos_valid(pv & ~sel), .window_pos_ready(a_prdy),
    .window_pos_eot(pe), .window_pos_x(px), .window_pos_y(py),
    .window_pos_scale(ps),
    .result_valid(rv & ~sel), .result_ready(a_rrdy), .result(rb),
    .detect_pos_valid(a_v), .detect_pos_ready(dr & ~sel),
    .detect_pos_eot(a_e), .detect_pos_hit(a_h),
    .detect_pos_x(a_x), .detect_pos_y(a_y), .detect_pos_scale(a_s),
    .detect_count(a_c), .scale_err(a_err)
  );

  window_pos_ms #(
    .IMG_WIDTH(45), .IMG_HEIGHT(45), .SCALE_NUM(3),
    .FIFO_DEPTH(8), .W_CNT(W_C), .REPORT_ALL(1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .window_pos_valid(pv & sel), .window_pos_ready(b_prdy),
    .window_pos_eot(pe), .window_pos_x(px), .window_pos_y(py),
    .window_pos_scale(ps),
    .result_valid(rv & sel), .result_ready(b_rrdy), .result(rb),
    .detect_pos_valid(b_v), .detect_pos_ready(dr & sel),
    .detect_pos_eot(b_e), .detect_pos_hit(b_h),
    .detect_pos_x(b_x), .detect_pos_y(b_y), .detect_pos_scale(b_s),
    .detect_count(b_c), .scale_err(b_err)
  );

  assign p_rdy = sel ? b_prdy : a_prdy;
  assign r_rdy = sel ? b_rrdy : a_rrdy;
  assign d_v   = sel ? b_v : a_v;
  assign d_e   = sel ? b_e : a_e;
  assign d_h   = sel ? b_h : a_h;
  assign d_x   = sel ? b_x : a_x;
  assign d_y   = sel ? b_y : a_y;
  assign d_s   = sel ? b_s : a_s;
  assign d_c   = sel ? b_c : a_c;
  assign s_err = sel ? b_err : a_err;

  // Frame-level model: walk windows in order, count hits, emit beats.
  function automatic void build_exp(input bit ra);
    int c;
    beat_t b;
    c = 0;
    exp_q.delete();
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i]) c = (c < CMAX) ? c + 1 : CMAX;
      if (rq[i] || wq[i].e || ra) begin
        b.x = wq[i].x;
        b.y = wq[i].y;
        b.s = wq[i].s;
        b.hit = rq[i];
        b.eot = wq[i].e;
        b.cnt = wq[i].e ? W_C'(c) : '0;
        exp_q.push_back(b);
      end
      if (wq[i].e) c = 0;
    end
  endfunction

  function automatic void add_win(input int x, input int y,
                                  input int s, input bit e, input bit r);
    win_t w;
    w.x = W_X'(x);
    w.y = W_Y'(y);
    w.s = W_S'(s);
    w.e = e;
    wq.push_back(w);
    rq.push_back(r);
  endfunction

  function automatic void gen_frames(input int nf, input int hit_pct);
    int len;
    for (int f = 0; f < nf; f++) begin
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++)
        add_win($urandom_range(44), $urandom_range(44), $urandom_range(2),
                i == len - 1, $urandom_range(99) < hit_pct);
    end
  endfunction

  function automatic void clear_stim();
    wq.delete();
    rq.delete();
    exp_q.delete();
    wi = 0;
    ri = 0;
  endfunction

  task automatic run_stream(input int vp, input int rp, input int dp);
    int cyc;
    beat_t b;
    cyc = 0;
    while ((wi < wq.size() || ri < rq.size() || exp_q.size() != 0)
           && cyc < 3000) begin
      pv = (wi < wq.size()) && ($urandom_range(99) < vp);
      if (wi < wq.size()) begin
        px = wq[wi].x;
        py = wq[wi].y;
        ps = wq[wi].s;
        pe = wq[wi].e;
      end
      rv = (ri < rq.size()) && ($urandom_range(99) < rp);
      if (ri < rq.size()) rb = rq[ri];
      dr = $urandom_range(99) < dp;
      @(negedge clk);
      if (pv && p_rdy) wi++;
      if (rv && r_rdy) ri++;
      if (d_v && dr) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_extra: got x=%0d y=%0d s=%0d hit=%0b eot=%0b cnt=%0d, none expected",
                   d_x, d_y, d_s, d_h, d_e, d_c);
        end else begin
          b = exp_q.pop_front();
          if ({d_x, d_y, d_s, d_h, d_e, d_c} !==
              {b.x, b.y, b.s, b.hit, b.eot, b.cnt})
            $display("FAIL beat: got x=%0d y=%0d s=%0d hit=%0b eot=%0b cnt=%0d, want x=%0d y=%0d s=%0d hit=%0b eot=%0b cnt=%0d",
                     d_x, d_y, d_s, d_h, d_e, d_c,
                     b.x, b.y, b.s, b.hit, b.eot, b.cnt);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    pv = 1'b0;
    rv = 1'b0;
    dr = 1'b1;
    checks++;
    if (cyc >= 3000)
      $display("FAIL stream_timeout: got %0d beats left, want 0", exp_q.size());
    else passed++;
  endtask

  task automatic do_reset();
    pv = 1'b0;
    rv = 1'b0;
    dr = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (p_rdy !== 1'b1) $display("FAIL rst_pready: got %0b want 1", p_rdy);
    else passed++;
    checks++;
    if (r_rdy !== 1'b0) $display("FAIL rst_rready: got %0b want 0", r_rdy);
    else passed++;
    checks++;
    if ({d_v, d_e, d_h, d_x, d_y, d_s} !== '0)
      $display("FAIL rst_out: got v=%0b e=%0b h=%0b x=%0d want all 0",
               d_v, d_e, d_h, d_x);
    else passed++;
    checks++;
    if ({d_c, s_err} !== '0)
      $display("FAIL rst_cnt_err: got cnt=%0d err=%0b want 0", d_c, s_err);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_stim();
    add_win(0, 0, 0, 0, 0);
    add_win(1, 0, 0, 0, 1);
    add_win(2, 0, 0, 0, 0);
    add_win(3, 0, 0, 1, 1);
    build_exp(0);
    checks++;
    if (exp_q.size() != 2) $display("FAIL basic_nbeats: got %0d want 2", exp_q.size());
    else passed++;
    run_stream(100, 100, 100);
  endtask

  task automatic test_last_miss();
    clear_stim();
    add_win(0, 0, 0, 0, 0);
    add_win(1, 0, 0, 0, 1);
    add_win(2, 0, 0, 0, 0);
    add_win(3, 0, 0, 1, 0);
    build_exp(0);
    run_stream(100, 100, 100);
  endtask

  task automatic test_report_all();
    sel = 1'b1;
    clear_stim();
    add_win(0, 0, 0, 0, 0);
    add_win(1, 0, 0, 0, 1);
    add_win(2, 0, 0, 0, 0);
    add_win(3, 0, 0, 1, 0);
    build_exp(1);
    run_stream(100, 100, 100);
    clear_stim();
    gen_frames(6, 50);
    build_exp(1);
    run_stream(70, 60, 60);
    sel = 1'b0;
  endtask

  task automatic test_fifo_full();
    int cyc;
    clear_stim();
    for (int i = 0; i < 9; i++) add_win(i, i, i % 3, i == 8, 1);
    build_exp(0);
    pv = 1'b1;
    rv = 1'b0;
    dr = 1'b1;
    cyc = 0;
    while (wi < 8 && cyc < 20) begin
      px = wq[wi].x;
      py = wq[wi].y;
      ps = wq[wi].s;
      pe = wq[wi].e;
      @(negedge clk);
      if (pv && p_rdy) wi++;
      @(posedge clk);
      #1;
      cyc++;
    end
    px = wq[8].x;
    py = wq[8].y;
    ps = wq[8].s;
    pe = wq[8].e;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (p_rdy !== 1'b0) $display("FAIL full_ready_low: got %0b want 0", p_rdy);
      else passed++;
      @(posedge clk);
      #1;
    end
    rv = 1'b1;
    rb = 1'b1;
    @(negedge clk);
    checks++;
    if ({r_rdy, p_rdy} !== 2'b10)
      $display("FAIL full_pop_cycle: got rrdy=%0b prdy=%0b want 1,0", r_rdy, p_rdy);
    else passed++;
    @(posedge clk);
    #1;
    ri = 1;
    checks++;
    if (p_rdy !== 1'b1) $display("FAIL full_ready_after_pop: got %0b want 1", p_rdy);
    else passed++;
    run_stream(70, 70, 70);
  endtask

  task automatic test_backpressure();
    clear_stim();
    dr = 1'b0;
    pv = 1'b1;
    px = 5; py = 6; ps = 1; pe = 1'b0;
    @(posedge clk);
    #1;
    px = 7; py = 8; ps = 0; pe = 1'b1;
    @(posedge clk);
    #1;
    pv = 1'b0;
    rv = 1'b1;
    rb = 1'b1;
    @(negedge clk);
    checks++;
    if (r_rdy !== 1'b1) $display("FAIL bp_first_accept: got %0b want 1", r_rdy);
    else passed++;
    @(posedge clk);
    #1;
    rb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({d_v, d_x, d_y, d_s, d_h, d_e, r_rdy} !==
          {1'b1, W_X'(5), W_Y'(6), W_S'(1), 1'b1, 1'b0, 1'b0})
        $display("FAIL bp_hold: got v=%0b x=%0d y=%0d s=%0d h=%0b e=%0b rrdy=%0b want 1,5,6,1,1,0,0",
                 d_v, d_x, d_y, d_s, d_h, d_e, r_rdy);
      else passed++;
      @(posedge clk);
      #1;
    end
    dr = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_v, d_x, r_rdy} !== {1'b1, W_X'(5), 1'b1})
      $display("FAIL bp_release: got v=%0b x=%0d rrdy=%0b want 1,5,1", d_v, d_x, r_rdy);
    else passed++;
    @(posedge clk);
    #1;
    rv = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_v, d_x, d_y, d_s, d_h, d_e, d_c} !==
        {1'b1, W_X'(7), W_Y'(8), W_S'(0), 1'b0, 1'b1, W_C'(1)})
      $display("FAIL bp_eot: got v=%0b x=%0d y=%0d s=%0d h=%0b e=%0b c=%0d want 1,7,8,0,0,1,1",
               d_v, d_x, d_y, d_s, d_h, d_e, d_c);
    else passed++;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (d_v !== 1'b0) $display("FAIL bp_drained: got %0b want 0", d_v);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_scale();
    checks++;
    if (s_err !== 1'b0) $display("FAIL scale_err_pre: got %0b want 0", s_err);
    else passed++;
    clear_stim();
    add_win(1, 1, 0, 0, 1);
    add_win(2, 2, 1, 0, 1);
    add_win(3, 3, 1, 0, 0);
    add_win(4, 4, 3, 1, 1);
    build_exp(0);
    run_stream(80, 80, 80);
    checks++;
    if (s_err !== 1'b1) $display("FAIL scale_err_set: got %0b want 1", s_err);
    else passed++;
    clear_stim();
    gen_frames(2, 60);
    build_exp(0);
    run_stream(80, 80, 80);
    checks++;
    if (s_err !== 1'b1) $display("FAIL scale_err_sticky: got %0b want 1", s_err);
    else passed++;
    do_reset();
    checks++;
    if (s_err !== 1'b0) $display("FAIL scale_err_rst: got %0b want 0", s_err);
    else passed++;
  endtask

  task automatic test_mid_reset();
    clear_stim();
    dr = 1'b0;
    pv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      px = W_X'(20 + i); py = 1; ps = 0; pe = 1'b0;
      @(posedge clk);
      #1;
    end
    pv = 1'b0;
    rv = 1'b1;
    rb = 1'b1;
    @(posedge clk);
    #1;
    rv = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_v, d_x} !== {1'b1, W_X'(20)})
      $display("FAIL mrst_pre: got v=%0b x=%0d want 1,20", d_v, d_x);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_v, p_rdy, r_rdy, d_c} !== {1'b0, 1'b1, 1'b0, W_C'(0)})
      $display("FAIL mrst_post: got v=%0b prdy=%0b rrdy=%0b c=%0d want 0,1,0,0",
               d_v, p_rdy, r_rdy, d_c);
    else passed++;
    @(posedge clk);
    #1;
    dr = 1'b1;
    add_win(9, 9, 2, 0, 1);
    add_win(10, 9, 0, 0, 0);
    add_win(11, 9, 1, 1, 1);
    build_exp(0);
    run_stream(90, 90, 90);
  endtask

  task automatic test_random();
    clear_stim();
    gen_frames(10, 70);
    build_exp(0);
    run_stream(60, 60, 50);
    clear_stim();
    gen_frames(6, 90);
    build_exp(0);
    run_stream(100, 100, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_miss();
    test_report_all();
    test_fifo_full();
    test_backpressure();
    test_scale();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
